// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, queues {pc,word} for decode.
// Optional perf counters perf_fetched/perf_flushed are built when FETCH_PERF_CNT_EN is defined.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc, req_pc;
  logic [31:0]     redir_aligned;
  logic [31:0]     q_data [QDEPTH];
  logic [31:0]     q_pc   [QDEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            req_fire, credit, push, pop;

  assign redir_aligned  = redirect_pc & ~32'd3;
  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = fetch_pc;
  assign inst_valid     = (count != '0);
  assign inst_data      = q_data[rd_ptr];
  assign inst_pc        = q_pc[rd_ptr];

  // Occupancy plus the in-flight word, taken before any pop this cycle.
  assign occ      = {1'b0, count} + {{CW{1'b0}}, (state == S_WAIT)};
  assign credit   = (occ < QD);
  assign req_fire = (state == S_REQ) && imem_req_ready;
  assign push     = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (redirect_valid || credit) state_nxt = S_REQ;
      S_REQ:  if (req_fire) state_nxt = redirect_valid ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid)      state_nxt = (redirect_valid || credit) ? S_REQ : S_IDLE;
        else if (redirect_valid) state_nxt = S_DROP;
      end
      S_DROP: if (imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      state <= state_nxt;
      if (redirect_valid)  fetch_pc <= redir_aligned;
      else if (req_fire)   fetch_pc <= fetch_pc + 32'd4;
      if (req_fire) req_pc <= fetch_pc;
      if (push) begin
        q_data[wr_ptr] <= imem_rsp_data;
        q_pc[wr_ptr]   <= req_pc;
      end
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic discard;
  assign discard = imem_rsp_valid &&
                   ((state == S_DROP) || ((state == S_WAIT) && redirect_valid));

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      perf_flushed <= perf_flushed + (redirect_valid ? 32'(count) : 32'd0) + 32'(discard);
    end
  end
`endif

endmodule
